// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: fetches the word at the PC, issues it to control_unit, waits for completion.
// Optional memory timeout is enabled with FETCH_SEQ_TIMEOUT_EN.
module fetch_sequencer #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              fault_clr,
   input  logic [ADDR_W-1:0] pc_val,
   output logic              pc_inc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic              new_instr,
   input  logic              cu_done,
   output logic              halted,
   output logic              fault,
   output logic [15:0]       instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ISSUE,
      S_EXEC,
      S_FAULT
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic        load_addr;
   logic        load_instr;
   logic        retire;
   logic [15:0] count_reg;

`ifdef FETCH_SEQ_TIMEOUT_EN
   localparam int TIMER_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   logic [TIMER_W-1:0] timer_reg;
   logic               timer_expired;

   // Timer counts completed REQ cycles; expiry on the last one unless ack arrives then.
   assign timer_expired = (timer_reg == TIMER_W'(MEM_TIMEOUT - 1));
`else
   logic unused_cfg;
   assign unused_cfg = fault_clr | (MEM_TIMEOUT < 0);
`endif

   always_comb begin
      state_next = state_reg;
      load_addr  = 1'b0;
      load_instr = 1'b0;
      retire     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (run) begin
               state_next = S_REQ;
               load_addr  = 1'b1;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_next = S_ISSUE;
               load_instr = 1'b1;
            end
`ifdef FETCH_SEQ_TIMEOUT_EN
            else if (timer_expired) begin
               state_next = S_FAULT;
            end
`endif
         end
         S_ISSUE: state_next = S_EXEC;
         S_EXEC: begin
            if (cu_done) begin
               retire = 1'b1;
               if (run) begin
                  state_next = S_REQ;
                  load_addr  = 1'b1;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         S_FAULT: begin
`ifdef FETCH_SEQ_TIMEOUT_EN
            if (fault_clr) state_next = S_IDLE;
`else
            state_next = S_IDLE;
`endif
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they change with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         mem_req   <= 1'b0;
         new_instr <= 1'b0;
         pc_inc    <= 1'b0;
         halted    <= 1'b1;
      end else begin
         state_reg <= state_next;
         mem_req   <= (state_next == S_REQ);
         new_instr <= (state_next == S_ISSUE);
         pc_inc    <= (state_next == S_ISSUE);
         halted    <= (state_next == S_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr  <= '0;
         instr     <= '0;
         count_reg <= '0;
      end else begin
         if (load_addr)  mem_addr  <= pc_val;
         if (load_instr) instr     <= mem_rdata;
         if (retire)     count_reg <= count_reg + 16'd1;
      end
   end

   assign instr_count = count_reg;

`ifdef FETCH_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_reg <= '0;
         fault     <= 1'b0;
      end else begin
         fault <= (state_next == S_FAULT);
         if (load_addr)
            timer_reg <= '0;
         else if (state_reg == S_REQ && !mem_ack && !timer_expired)
            timer_reg <= timer_reg + 1'b1;
      end
   end
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of expected instruction words.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        fault_clr;
   logic [15:0] pc_val;
   logic        pc_inc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic        new_instr;
   logic        cu_done;
   logic        halted;
   logic        fault;
   logic [15:0] instr_count;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_count = 16'd0;
   logic [15:0] last_instr = 16'd0;
   logic [15:0] sb_q[$];

   fetch_sequencer #(.ADDR_W(16), .DATA_W(16), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .run(run), .fault_clr(fault_clr), .pc_val(pc_val),
      .pc_inc(pc_inc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .instr(instr), .new_instr(new_instr), .cu_done(cu_done),
      .halted(halted), .fault(fault), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // From IDLE (or mid-stream) raise run with a PC; REQ must be visible one cycle later.
   task automatic start_fetch(input logic [15:0] addr);
      pc_val = addr;
      run    = 1'b1;
      step();
      chk("req_after_run", {31'd0, mem_req}, 32'd1);
      chk("req_addr", {16'd0, mem_addr}, {16'd0, addr});
      chk("not_halted", {31'd0, halted}, 32'd0);
   endtask

   // Hold off ack for 'delay' cycles, then ack; returns at the negedge inside ISSUE.
   task automatic respond(input logic [15:0] data, input int delay);
      logic [15:0] exp_w;
      sb_q.push_back(data);
      mem_rdata = ~data;
      for (int i = 0; i < delay; i++) begin
         step();
         chk("req_held", {31'd0, mem_req}, 32'd1);
         chk("no_fault_wait", {31'd0, fault}, 32'd0);
      end
      mem_ack   = 1'b1;
      mem_rdata = data;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      chk("new_instr_pulse", {31'd0, new_instr}, 32'd1);
      chk("pc_inc_pulse", {31'd0, pc_inc}, 32'd1);
      chk("req_drop_on_issue", {31'd0, mem_req}, 32'd0);
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         exp_w = sb_q.pop_front();
         chk("instr_word", {16'd0, instr}, {16'd0, exp_w});
         last_instr = exp_w;
      end
   endtask

   // Leave ISSUE, wait 'delay' cycles in EXEC, then pulse cu_done with the given run/pc.
   task automatic retire(input int delay, input logic run_val, input logic [15:0] next_pc);
      step();
      chk("new_instr_one_cycle", {31'd0, new_instr}, 32'd0);
      chk("pc_inc_one_cycle", {31'd0, pc_inc}, 32'd0);
      chk("instr_stable", {16'd0, instr}, {16'd0, last_instr});
      for (int i = 1; i < delay; i++) begin
         step();
         chk("exec_no_req", {31'd0, mem_req}, 32'd0);
      end
      run     = run_val;
      pc_val  = next_pc;
      cu_done = 1'b1;
      step();
      cu_done = 1'b0;
      exp_count = exp_count + 16'd1;
      chk("instr_count", {16'd0, instr_count}, {16'd0, exp_count});
      if (run_val) begin
         chk("next_req", {31'd0, mem_req}, 32'd1);
         chk("next_addr", {16'd0, mem_addr}, {16'd0, next_pc});
      end else begin
         chk("stop_halted", {31'd0, halted}, 32'd1);
         chk("stop_no_req", {31'd0, mem_req}, 32'd0);
      end
   endtask

   initial begin
      rst = 1'b0; run = 1'b0; fault_clr = 1'b0; pc_val = 16'h0000;
      mem_ack = 1'b0; mem_rdata = 16'h0000; cu_done = 1'b0;
      step();
      step();
      chk("rst_halted", {31'd0, halted}, 32'd1);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_instr", {16'd0, instr}, 32'd0);
      chk("rst_count", {16'd0, instr_count}, 32'd0);
      chk("rst_new_instr", {31'd0, new_instr}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      rst = 1'b1;
      step();

      // Stray ack/done while idle must be ignored.
      mem_ack = 1'b1; mem_rdata = 16'h1234; cu_done = 1'b1;
      step();
      mem_ack = 1'b0; cu_done = 1'b0;
      step();
      chk("idle_ign_halted", {31'd0, halted}, 32'd1);
      chk("idle_ign_req", {31'd0, mem_req}, 32'd0);
      chk("idle_ign_instr", {16'd0, instr}, 32'd0);
      chk("idle_ign_count", {16'd0, instr_count}, 32'd0);

      // Single fetch with a two-cycle ack delay.
      start_fetch(16'h0010);
      respond(16'h0BFC, 2);
      retire(1, 1'b0, 16'h0011);

      // Back-to-back fetches with cu_done three cycles after each issue.
      start_fetch(16'h0010);
      respond(16'hA501, 0);
      retire(3, 1'b1, 16'h0011);
      respond(16'h5A02, 1);
      retire(3, 1'b0, 16'h0012);

      // Stop requested during ISSUE: instruction still completes, then idle.
      start_fetch(16'h0020);
      respond(16'h7777, 0);
      run = 1'b0;
      retire(2, 1'b0, 16'h0021);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stop_stays_idle", {31'd0, mem_req}, 32'd0);
      end

      // Asynchronous reset in the middle of EXEC.
      start_fetch(16'h0030);
      respond(16'hC0DE, 0);
      step();
      run = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_halted", {31'd0, halted}, 32'd1);
      chk("arst_instr", {16'd0, instr}, 32'd0);
      chk("arst_addr", {16'd0, mem_addr}, 32'd0);
      chk("arst_count", {16'd0, instr_count}, 32'd0);
      chk("arst_new_instr", {31'd0, new_instr}, 32'd0);
      exp_count = 16'd0;
      step();
      rst = 1'b1;
      step();

      // Memory timeout behaviour.
`ifdef FETCH_SEQ_TIMEOUT_EN
      start_fetch(16'h0040);
      for (int i = 0; i < 14; i++) step();
      chk("to_req_cycle15", {31'd0, mem_req}, 32'd1);
      chk("to_no_fault_yet", {31'd0, fault}, 32'd0);
      step();
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_req_drop", {31'd0, mem_req}, 32'd0);
      step();
      chk("to_run_ignored", {31'd0, fault}, 32'd1);
      run = 1'b0; fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      chk("to_clr_fault", {31'd0, fault}, 32'd0);
      chk("to_clr_halted", {31'd0, halted}, 32'd1);
      start_fetch(16'h0041);
      respond(16'hBEEF, 14);
      chk("to_ack_wins", {31'd0, fault}, 32'd0);
      retire(1, 1'b0, 16'h0042);
`else
      start_fetch(16'h0040);
      respond(16'hBEEF, 20);
      chk("no_to_fault", {31'd0, fault}, 32'd0);
      retire(1, 1'b0, 16'h0041);
`endif

      // Counter wrap: preload the count to its maximum.
      force dut.count_reg = 16'hFFFF;
      step();
      release dut.count_reg;
      step();
      exp_count = 16'hFFFF;
      chk("wrap_preload", {16'd0, instr_count}, 32'h0000FFFF);
      start_fetch(16'h0050);
      respond(16'h0F0F, 0);
      retire(1, 1'b0, 16'h0051);
      chk("wrap_zero", {16'd0, instr_count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
